// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for the req/ack arbiter
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam logic        CMD_READ  = 1'b0;
  localparam logic        CMD_WRITE = 1'b1;
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector
// Returns the first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any_req,
  output logic [IW-1:0] idx
);

  int j;

  always_comb begin
    any_req = 1'b0;
    idx     = '0;
    j       = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any_req && req[j]) begin
        any_req = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/req_ack_arbiter.sv
// rtl/req_ack_arbiter.sv - round-robin share of one single-outstanding req/ack slave
// Optional BUSY timeout abort when ARB_TIMEOUT_EN is defined.
module req_ack_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        m_req,
  input  logic [N_MASTERS-1:0]        m_cmd,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  output logic [N_MASTERS-1:0]        m_ack,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_err,
  output logic                        s_req,
  output logic                        s_cmd,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  input  logic                        s_ack,
  input  logic [DATA_W-1:0]           s_rdata
);

  localparam int IW = $clog2(N_MASTERS);

  state_t                state, state_n;
  logic [IW-1:0]         ptr, ptr_n, grant, grant_n, pick, grant_inc;
  logic                  any_req;
  logic                  s_req_n, s_cmd_n;
  logic [ADDR_W-1:0]     s_addr_n;
  logic [DATA_W-1:0]     s_wdata_n, m_rdata_n;
  logic [N_MASTERS-1:0]  m_ack_n;

  rr_pick #(.N(N_MASTERS), .IW(IW)) u_pick (
    .req     (m_req),
    .ptr     (ptr),
    .any_req (any_req),
    .idx     (pick)
  );

  assign grant_inc = (grant == IW'(N_MASTERS - 1)) ? '0 : grant + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          err, err_n;
  logic          timeout;

  // Fires on the edge that would take the count to TIMEOUT_CYCLES.
  assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign m_err   = err;
`else
  assign m_err   = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    grant_n   = grant;
    s_req_n   = s_req;
    s_cmd_n   = s_cmd;
    s_addr_n  = s_addr;
    s_wdata_n = s_wdata;
    m_ack_n   = '0;
    m_rdata_n = m_rdata;
`ifdef ARB_TIMEOUT_EN
    cnt_n     = cnt;
    err_n     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (any_req) begin
          grant_n   = pick;
          s_cmd_n   = m_cmd[pick];
          s_addr_n  = m_addr[int'(pick)*ADDR_W +: ADDR_W];
          s_wdata_n = m_wdata[int'(pick)*DATA_W +: DATA_W];
          s_req_n   = 1'b1;
          state_n   = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_n     = '0;
`endif
        end
      end
      BUSY: begin
        if (s_ack) begin
          s_req_n        = 1'b0;
          m_ack_n[grant] = 1'b1;
          m_rdata_n      = (s_cmd == CMD_READ) ? s_rdata : '0;
          ptr_n          = grant_inc;
          state_n        = RECOVER;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          if (cnt != CW'(TIMEOUT_CYCLES)) cnt_n = cnt + 1'b1;
          if (timeout) begin
            s_req_n        = 1'b0;
            m_ack_n[grant] = 1'b1;
            err_n          = 1'b1;
            m_rdata_n      = DATA_W'(ERR_DATA);
            ptr_n          = grant_inc;
            state_n        = RECOVER;
          end
        end
`endif
      end
      RECOVER: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      s_req   <= 1'b0;
      s_cmd   <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_ack   <= '0;
      m_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
      cnt     <= '0;
      err     <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      grant   <= grant_n;
      s_req   <= s_req_n;
      s_cmd   <= s_cmd_n;
      s_addr  <= s_addr_n;
      s_wdata <= s_wdata_n;
      m_ack   <= m_ack_n;
      m_rdata <= m_rdata_n;
`ifdef ARB_TIMEOUT_EN
      cnt     <= cnt_n;
      err     <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_req_ack_arbiter.sv
// tb/tb_req_ack_arbiter.sv - scoreboard bench for req_ack_arbiter
// Timeout vectors are built only when ARB_TIMEOUT_EN is defined.
module tb_req_ack_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_req, m_cmd, m_ack;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
  logic [AW-1:0]   s_addr;
  logic            m_err, s_req, s_cmd, s_ack;

  req_ack_arbiter #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_cmd(m_cmd), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every ack pulse pops one expected completion.
  always @(negedge clk) begin
    if (!rst && m_ack != '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(m_ack), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("mon_ack_onehot", 32'(m_ack), 32'd1 << mon_e.idx);
        check("mon_rdata", m_rdata, mon_e.rdata);
        check("mon_err", 32'(m_err), 32'(mon_e.err));
      end
    end
  end

  // Caller has driven m_req; lat = BUSY cycles without ack before the ack cycle.
  task automatic run_txn(input int mst, input logic cmd, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input logic [31:0] rdata);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!s_req && n < 8);
    check("s_req_rise_latency", 32'(n), 32'd1);
    if (!s_req) return;
    check("s_addr", s_addr, addr);
    check("s_cmd", 32'(s_cmd), 32'(cmd));
    if (cmd) check("s_wdata", s_wdata, wdata);
    repeat (lat) begin @(posedge clk); #1; end
    check("busy_s_req_held", 32'(s_req), 32'd1);
    check("busy_s_addr_held", s_addr, addr);
    check("busy_s_cmd_held", 32'(s_cmd), 32'(cmd));
    if (cmd) check("busy_s_wdata_held", s_wdata, wdata);
    e.idx   = mst;
    e.rdata = cmd ? 32'd0 : rdata;
    e.err   = 1'b0;
    sb.push_back(e);
    s_ack   = 1'b1;
    s_rdata = rdata;
    @(posedge clk); #1;
    s_ack   = 1'b0;
    s_rdata = $urandom;
    check("ack_lag_one", 32'(m_ack), 32'd1 << mst);
    check("s_req_drop", 32'(s_req), 32'd0);
    @(posedge clk); #1;
    check("ack_one_cycle", 32'(m_ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1; m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_req", 32'(s_req), 32'd0);
    check("rst_m_ack", 32'(m_ack), 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check("rst_m_err", 32'(m_err), 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    rst = 1'b0;

    // Single read by master 0.
    m_cmd[0] = 1'b0; m_addr[0*AW +: AW] = 32'h10; m_req = 2'b01;
    run_txn(0, 1'b0, 32'h10, 32'h0, 3, 32'h5);
    m_req = '0;

    // Master 1 write: read data returned as 0.
    m_cmd[1] = 1'b1; m_addr[1*AW +: AW] = 32'h20; m_wdata[1*DW +: DW] = 32'hA5A5_0001;
    m_req = 2'b10;
    run_txn(1, 1'b1, 32'h20, 32'hA5A5_0001, 2, 32'h1234_5678);
    m_req = '0;

    // Both request continuously: 0,1,0,1.
    m_cmd = 2'b00; m_addr[0*AW +: AW] = 32'h100; m_addr[1*AW +: AW] = 32'h104;
    m_req = 2'b11;
    for (int k = 0; k < 4; k++)
      run_txn(k % 2, 1'b0, (k % 2) ? 32'h104 : 32'h100, 32'h0, k, 32'h1000 + k);
    m_req = '0;

    // Move the pointer to 1, then reset mid-BUSY.
    m_addr[0*AW +: AW] = 32'h200; m_req = 2'b01;
    run_txn(0, 1'b0, 32'h200, 32'h0, 1, 32'h7);
    m_req = 2'b11; m_addr[1*AW +: AW] = 32'h204;
    @(posedge clk); #1;
    check("rr_ptr_grant1", s_addr, 32'h204);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy_s_req", 32'(s_req), 32'd0);
    check("rst_busy_m_ack", 32'(m_ack), 32'd0);
    run_txn(0, 1'b0, 32'h200, 32'h0, 1, 32'h9);
    m_req = '0;

`ifdef ARB_TIMEOUT_EN
    // Slave never acks: abort after 4 BUSY cycles.
    m_addr[0*AW +: AW] = 32'h300; m_req = 2'b01;
    @(posedge clk); #1;
    check("to_s_req_rise", 32'(s_req), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    check("to_no_early_ack", 32'(m_ack), 32'd0);
    e.idx = 0; e.rdata = 32'hDEAD_BEEF; e.err = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    check("to_m_ack", 32'(m_ack), 32'd1);
    check("to_m_err", 32'(m_err), 32'd1);
    check("to_s_req_low", 32'(s_req), 32'd0);
    check("to_m_rdata", m_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    check("to_ack_clear", 32'(m_ack), 32'd0);
    check("to_err_clear", 32'(m_err), 32'd0);
    m_req = '0;

    // Ack on the 4th BUSY cycle beats the timeout.
    m_addr[0*AW +: AW] = 32'h304; m_req = 2'b01;
    run_txn(0, 1'b0, 32'h304, 32'h0, 3, 32'h55);
    m_req = '0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/req_ack_arbiter.md
Name: req_ack_arbiter

Overview:
- Shares one req/ack slave (single-outstanding, 32-bit addr/data) between N_MASTERS requesters.
- Round-robin grant. Each winning request is latched and replayed to the slave. The slave's one-cycle ack and read data return to the granted master.
- Sits between bus masters and the counter-style slave. Only one transaction is outstanding at any time.

Parameters:
- N_MASTERS, 2, number of requesters (>=2)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 16, BUSY cycles before abort (used only with the optional feature)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- m_req  in  N_MASTERS  per-master request; held until its m_ack
- m_cmd  in  N_MASTERS  per-master command; 0=read, 1=write
- m_addr  in  N_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  N_MASTERS*DATA_W  packed write data, same packing
- m_ack  out  N_MASTERS  one-hot, one-cycle completion pulse
- m_rdata  out  DATA_W  shared read data; valid only while m_ack[i]=1 and the cmd was read
- m_err  out  1  pulses with m_ack on an aborted transaction
- s_req  out  1  request to slave
- s_cmd  out  1  latched cmd
- s_addr  out  ADDR_W  latched address
- s_wdata  out  DATA_W  latched write data
- s_ack  in  1  slave completion pulse
- s_rdata  in  DATA_W  slave read data; sampled when s_ack=1

Behaviour:
- Reset (rst=1 at a posedge) takes precedence over everything:
  - state=IDLE, rr pointer=0, grant=0, counter=0
  - all outputs 0, including s_req and m_ack
  - Reset in BUSY drops s_req on the next edge with no m_ack. The slave must tolerate the abandoned request.
- IDLE:
  - If any m_req is set, pick the first requester at or after the pointer, wrapping modulo N_MASTERS.
  - Latch grant, cmd, addr and wdata. Set s_req=1 and go to BUSY.
  - Result: s_req rises 1 cycle after m_req is seen.
- BUSY:
  - s_req, s_cmd, s_addr and s_wdata are held stable. Input m_* changes are ignored.
  - On s_ack=1: s_req<=0; m_ack[grant]<=1 for exactly one cycle; m_rdata<=s_rdata for a read, 0 for a write; pointer<=(grant+1) mod N_MASTERS; go to RECOVER.
  - Result: m_ack lags s_ack by 1 cycle.
  - A master dropping m_req while BUSY is a protocol violation. The transaction still completes and is acked.
- RECOVER:
  - Exactly one cycle; m_ack returns to 0; then IDLE.
  - The acked master must drop m_req in the cycle after its m_ack. RECOVER guarantees that request is not re-arbitrated.
- Throughput: one transaction per (slave latency + 3) cycles at most.
- Fairness:
  - With all masters requesting continuously, grants rotate 0,1,...,N-1,0.
  - A lone requester is granted back-to-back.
- m_rdata holds its last value outside ack cycles. Consumers sample it only on m_ack.
- Widths:
  - grant/pointer use $clog2(N_MASTERS) bits.
  - The counter uses $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.

Optional Feature:
- Macro: ARB_TIMEOUT_EN
- Defined:
  - The counter clears on entry to BUSY and increments each BUSY cycle without s_ack.
  - When the count reaches TIMEOUT_CYCLES: s_req<=0; m_ack[grant]<=1; m_err<=1; m_rdata<=ERR_DATA; advance pointer; go to RECOVER.
  - If s_ack and timeout occur in the same cycle, the ack wins and m_err stays 0.
- Undefined:
  - No counter is built; BUSY waits indefinitely.
  - m_err is tied 0 and TIMEOUT_CYCLES is unused.

Decomposition:
- Package bus_pkg:
  - state enum (IDLE, BUSY, RECOVER)
  - CMD_READ=1'b0, CMD_WRITE=1'b1
  - ERR_DATA=32'hDEAD_BEEF
- Sub-module rr_pick:
  - Combinational round-robin selector.
  - Inputs: request vector and pointer. Outputs: any_req and grant index.
  - Instantiated once.

Test Plan:
- Single read, slave acks after 3 BUSY cycles with s_rdata=32'h5 (master 0, m_cmd=0, m_addr=32'h10):
  - s_req rises 1 cycle after m_req, with s_addr=32'h10.
  - m_ack[0]=1 for one cycle, 1 cycle after s_ack, with m_rdata=32'h5.
- Master 1 write, m_wdata=32'hA5A5_0001:
  - s_cmd=1 and s_wdata=32'hA5A5_0001 held for all of BUSY.
  - At m_ack[1], m_rdata=0 and m_ack[0] stays 0.
- Both masters request continuously for 4 transactions -> grant order 0,1,0,1; m_ack is never set for two masters at once.
- rst=1 for one cycle in the 2nd BUSY cycle -> next edge s_req=0, m_ack=0, state IDLE; the following arbitration starts from master 0.
- ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, slave never acks:
  - m_ack[0] and m_err pulse after 4 BUSY cycles, with m_rdata=32'hDEAD_BEEF.
  - s_req is low on the same edge.
- ARB_TIMEOUT_EN defined, s_ack arrives exactly on the 4th BUSY cycle -> normal ack, m_err=0, m_rdata=s_rdata.
